// File: rtl/dcache_load_align_pkg.sv
// Load-type encodings shared by the load aligner and its extractor.
// Mirrors the store-side StoreType layout.
package dcache_load_align_pkg;

  typedef struct packed {
    logic       sign;
    logic [1:0] size;
    logic [1:0] left_or_right;
  } LoadType;

  localparam logic [1:0] LOADTYPE_LB  = 2'b00;
  localparam logic [1:0] LOADTYPE_LH  = 2'b01;
  localparam logic [1:0] LOADTYPE_LW  = 2'b10;

  localparam logic [1:0] LOADTYPE_LWL = 2'b10;
  localparam logic [1:0] LOADTYPE_LWR = 2'b01;

endpackage

// File: rtl/dcache_load_align_extract.sv
// Combinational load extractor: byte/half/word select, extension, LWL/LWR merge.
// LWL/LWR merging is present only with DCACHE_LOAD_UNALIGNED_EN defined.
module load_extract
  import dcache_load_align_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  LoadType     loadtype,
  input  logic [31:0] rt_old,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] norm;

  always_comb begin
    b    = rdata[{offset, 3'b000} +: 8];
    h    = offset[1] ? rdata[31:16] : rdata[15:0];
    norm = '0;
    case (loadtype.size)
      LOADTYPE_LB: norm = {{24{loadtype.sign & b[7]}}, b};
      LOADTYPE_LH: norm = {{16{loadtype.sign & h[15]}}, h};
      LOADTYPE_LW: norm = rdata;
      default:     norm = '0;
    endcase
  end

`ifdef DCACHE_LOAD_UNALIGNED_EN
  always_comb begin
    data = norm;
    case (loadtype.left_or_right)
      LOADTYPE_LWL: begin
        case (offset)
          2'd0:    data = {rdata[7:0],  rt_old[23:0]};
          2'd1:    data = {rdata[15:0], rt_old[15:0]};
          2'd2:    data = {rdata[23:0], rt_old[7:0]};
          default: data = rdata;
        endcase
      end
      LOADTYPE_LWR: begin
        case (offset)
          2'd0:    data = rdata;
          2'd1:    data = {rt_old[31:24], rdata[31:8]};
          2'd2:    data = {rt_old[31:16], rdata[31:16]};
          default: data = {rt_old[31:8],  rdata[31:24]};
        endcase
      end
      default: data = norm;
    endcase
  end
`else
  logic unused_rt;
  assign unused_rt = ^rt_old;
  // Unaligned variants collapse to a plain word load.
  assign data = (loadtype.left_or_right == 2'b00) ? norm : rdata;
`endif

endmodule

// File: rtl/dcache_load_align.sv
// In-order DCache load tracker: aligns responses and holds results for WB.
// DCACHE_LOAD_UNALIGNED_EN enables per-entry rt_old storage for LWL/LWR.
module dcache_load_align
  import dcache_load_align_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_offset,
  input  LoadType     req_loadtype,
  input  logic [31:0] req_rt_old,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        resp_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]       off_q  [DEPTH];
  LoadType          lt_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] done_q;

  logic [PW-1:0]   wr_ptr, rs_ptr, rd_ptr;
  logic [CNTW-1:0] count, drop_cnt, npend;

  logic [CNTW:0] occ, fsum, fnext;
  logic          accept, pop, drop, land, stray;
  logic [31:0]   rt_sel, ext;

`ifdef DCACHE_LOAD_UNALIGNED_EN
  logic [31:0] rt_q [DEPTH];
  assign rt_sel = rt_q[rs_ptr];
`else
  logic unused_rt;
  assign unused_rt = ^req_rt_old;
  assign rt_sel    = '0;
`endif

  // Slots plus drop credits never exceed DEPTH, so every response has a home.
  assign occ       = {1'b0, count} + {1'b0, drop_cnt};
  assign req_ready = !rst && (occ < (CNTW+1)'(DEPTH));

  assign out_valid = done_q[rd_ptr];
  assign out_data  = data_q[rd_ptr];

  assign accept = req_valid && req_ready && !flush;
  assign pop    = out_valid && out_ready && !flush;
  assign drop   = resp_valid && (flush || drop_cnt != '0);
  assign land   = resp_valid && !drop && npend != '0;
  assign stray  = resp_valid && !drop && npend == '0;

  assign fsum  = {1'b0, drop_cnt} + {1'b0, npend};
  assign fnext = fsum - (CNTW+1)'(resp_valid && fsum != '0);

  load_extract u_extract (
    .rdata    (resp_rdata),
    .offset   (off_q[rs_ptr]),
    .loadtype (lt_q[rs_ptr]),
    .rt_old   (rt_sel),
    .data     (ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rs_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      npend    <= '0;
      drop_cnt <= '0;
      done_q   <= '0;
      resp_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        off_q[i]  <= '0;
        lt_q[i]   <= '0;
      end
    end else begin
      resp_err <= stray;
      if (flush) begin
        wr_ptr   <= '0;
        rs_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        npend    <= '0;
        done_q   <= '0;
        drop_cnt <= CNTW'(fnext);
      end else begin
        if (drop) drop_cnt <= drop_cnt - CNTW'(1);
        if (accept) begin
          off_q[wr_ptr]  <= req_offset;
          lt_q[wr_ptr]   <= req_loadtype;
          done_q[wr_ptr] <= 1'b0;
          wr_ptr         <= wr_ptr + PW'(1);
        end
        if (land) begin
          data_q[rs_ptr] <= ext;
          done_q[rs_ptr] <= 1'b1;
          rs_ptr         <= rs_ptr + PW'(1);
        end
        if (pop) begin
          done_q[rd_ptr] <= 1'b0;
          rd_ptr         <= rd_ptr + PW'(1);
        end
        count <= count + CNTW'(accept) - CNTW'(pop);
        npend <= npend + CNTW'(accept) - CNTW'(land);
      end
    end
  end

`ifdef DCACHE_LOAD_UNALIGNED_EN
  always_ff @(posedge clk) begin
    if (accept) rt_q[wr_ptr] <= req_rt_old;
  end
`endif

endmodule

// File: tb/tb_dcache_load_align.sv
// Scoreboard bench for dcache_load_align (DEPTH=2).
// Expected results are queued at response time and checked when WB pops.
module tb_dcache_load_align;
  import dcache_load_align_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_offset;
  LoadType     req_loadtype;
  logic [31:0] req_rt_old;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        resp_err;

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] exp_q [$];

`ifdef DCACHE_LOAD_UNALIGNED_EN
  localparam logic [31:0] EXP_LWL = 32'hCCDD_3344;
  localparam logic [31:0] EXP_LWR = 32'h11AA_BBCC;
`else
  localparam logic [31:0] EXP_LWL = 32'hAABB_CCDD;
  localparam logic [31:0] EXP_LWR = 32'hAABB_CCDD;
`endif

  dcache_load_align #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_offset   (req_offset),
    .req_loadtype (req_loadtype),
    .req_rt_old   (req_rt_old),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic LoadType lt(input logic s, input logic [1:0] sz,
                                 input logic [1:0] lr);
    LoadType t;
    t.sign          = s;
    t.size          = sz;
    t.left_or_right = lr;
    return t;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("out_unexpected", {31'b0, out_valid}, 32'd0);
      else check("out_data", out_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] off, input LoadType t,
                     input logic [31:0] rt);
    check("req_ready", {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_offset   = off;
    req_loadtype = t;
    req_rt_old   = rt;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic resp(input logic [31:0] d, input logic push,
                      input logic [31:0] exp);
    resp_valid = 1'b1;
    resp_rdata = d;
    if (push) exp_q.push_back(exp);
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic load(input string tag, input logic [1:0] off, input LoadType t,
                      input logic [31:0] rt, input logic [31:0] d,
                      input logic [31:0] exp);
    req(off, t, rt);
    check({tag, "_pre_valid"}, {31'b0, out_valid}, 32'd0);
    resp(d, 1'b1, exp);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_offset = '0; req_loadtype = '0;
    req_rt_old = '0; resp_valid = 1'b0; resp_rdata = '0; flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", {31'b0, req_ready}, 32'd1);

    resp(32'hDEAD_BEEF, 1'b0, '0);
    check("stray_err", {31'b0, resp_err}, 32'd1);
    check("stray_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("stray_err_clr", {31'b0, resp_err}, 32'd0);

    load("lb",   2'd3, lt(1'b1, LOADTYPE_LB, 2'b00), '0, 32'h80AA_BBCC, 32'hFFFF_FF80);
    load("lbu",  2'd3, lt(1'b0, LOADTYPE_LB, 2'b00), '0, 32'h80AA_BBCC, 32'h0000_0080);
    load("lh2",  2'd2, lt(1'b1, LOADTYPE_LH, 2'b00), '0, 32'h1234_8001, 32'h0000_1234);
    load("lh0",  2'd0, lt(1'b1, LOADTYPE_LH, 2'b00), '0, 32'h1234_8001, 32'hFFFF_8001);
    load("lhu0", 2'd0, lt(1'b0, LOADTYPE_LH, 2'b00), '0, 32'h1234_8001, 32'h0000_8001);
    load("lw",   2'd0, lt(1'b0, LOADTYPE_LW, 2'b00), '0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    load("lbad", 2'd0, lt(1'b1, 2'b11, 2'b00), '0, 32'hCAFE_F00D, 32'h0);
    load("lwl",  2'd1, lt(1'b0, LOADTYPE_LW, LOADTYPE_LWL), 32'h1122_3344,
         32'hAABB_CCDD, EXP_LWL);
    load("lwr",  2'd1, lt(1'b0, LOADTYPE_LW, LOADTYPE_LWR), 32'h1122_3344,
         32'hAABB_CCDD, EXP_LWR);

    // Back-pressure with both slots full
    out_ready = 1'b0;
    req(2'd1, lt(1'b1, LOADTYPE_LB, 2'b00), '0);
    req(2'd0, lt(1'b0, LOADTYPE_LW, 2'b00), '0);
    check("full_ready", {31'b0, req_ready}, 32'd0);
    resp(32'h0000_F100, 1'b1, 32'hFFFF_FFF1);
    resp(32'h0102_0304, 1'b1, 32'h0102_0304);
    repeat (2) tick();
    check("bp_ready", {31'b0, req_ready}, 32'd0);
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    check("bp_head", out_data, 32'hFFFF_FFF1);
    out_ready = 1'b1;
    repeat (3) tick();
    check("bp_drained", exp_q.size(), 32'd0);
    check("bp_ready_back", {31'b0, req_ready}, 32'd1);

    // Flush with two outstanding, no same-cycle response
    req(2'd0, lt(1'b0, LOADTYPE_LW, 2'b00), '0);
    req(2'd0, lt(1'b0, LOADTYPE_LW, 2'b00), '0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid", {31'b0, out_valid}, 32'd0);
    check("fl_ready", {31'b0, req_ready}, 32'd0);
    resp(32'h1111_1111, 1'b0, '0);
    check("fl_drop1_err", {31'b0, resp_err}, 32'd0);
    check("fl_drop1_valid", {31'b0, out_valid}, 32'd0);
    resp(32'h2222_2222, 1'b0, '0);
    check("fl_drop2_err", {31'b0, resp_err}, 32'd0);
    check("fl_drop2_valid", {31'b0, out_valid}, 32'd0);
    load("fl_after", 2'd2, lt(1'b0, LOADTYPE_LH, 2'b00), '0, 32'hBEEF_0000,
         32'h0000_BEEF);

    // Flush coinciding with a response: only one further drop
    req(2'd0, lt(1'b0, LOADTYPE_LW, 2'b00), '0);
    req(2'd0, lt(1'b0, LOADTYPE_LW, 2'b00), '0);
    flush = 1'b1;
    resp(32'h3333_3333, 1'b0, '0);
    flush = 1'b0;
    check("flr_err", {31'b0, resp_err}, 32'd0);
    resp(32'h4444_4444, 1'b0, '0);
    check("flr_drop_err", {31'b0, resp_err}, 32'd0);
    resp(32'h5555_5555, 1'b0, '0);
    check("flr_stray_err", {31'b0, resp_err}, 32'd1);
    check("flr_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("end_queue", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_load_align.md
Name: dcache_load_align

Overview:
- Load-side counterpart of the MEM1 store byte-enable/data generator.
- Tracks outstanding DCache load requests in order, then aligns and sign/zero-extends the returned word for LB/LBU/LH/LHU/LW/LWL/LWR.
- Holds each result until the WB side accepts it.
- Sits between MEM1 (request side) and MEM2/WB (result side); absorbs in-flight responses across pipeline flushes.

Parameters:
- DEPTH, 2, max entries awaiting response or awaiting WB acceptance (power of 2, ≥2).
- CNTW, $clog2(DEPTH+1), width of occupancy and drop counters.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM1 issues a load to DCache this cycle.
- req_ready  out  1  an entry is free; a request is accepted only when req_valid && req_ready.
- req_offset  in  2  address bits [1:0].
- req_loadtype  in  LoadType  {sign, size[1:0], left_or_right[1:0]}.
- req_rt_old  in  32  current rt value, used to merge LWL/LWR.
- resp_valid  in  1  DCache returns read data; cannot be back-pressured.
- resp_rdata  in  32  raw aligned word from DCache.
- flush  in  1  discard all entries and all in-flight responses.
- out_valid  out  1  head entry has its data.
- out_ready  in  1  WB consumes the head entry.
- out_data  out  32  aligned/extended load result.
- resp_err  out  1  one-cycle pulse: response arrived with nothing outstanding.

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries {offset, loadtype, rt_old, data, done}.
  - Three pointers: wr_ptr (alloc), rs_ptr (next to receive response), rd_ptr (head).
  - Occupancy count; drop_cnt counts responses to discard.
- req_ready = !rst && (count + drop_cnt < DEPTH). This guarantees every returning response has a slot or a drop credit.
- Accept: write the fields at wr_ptr, done=0, advance wr_ptr, count+1.
- Response handling:
  - If drop_cnt != 0: decrement drop_cnt and discard the data.
  - Else if an entry is pending (rs_ptr != wr_ptr, or count > entries already done): compute the extracted result from resp_rdata and that entry's fields, store it as data, set done=1, advance rs_ptr.
  - Else: discard the data and pulse resp_err next cycle.
- Output: out_valid = head done; out_data = head data, registered from entry storage. Response in cycle N → out_valid in cycle N+1 at the earliest.
- Pop when out_valid && out_ready: advance rd_ptr, count-1. Accept and pop in the same cycle leave count unchanged.
- Full: count == DEPTH → req_ready=0; responses still land in existing entries.
- Extraction rules (normal loads, left_or_right=00):
  - size 00: byte at offset.
  - size 01: half at offset[1].
  - size 10: whole word.
  - Extension: sign=1 sign-extends, sign=0 zero-extends.
- LWL (left_or_right=10), by offset 0/1/2/3 (m = resp_rdata, r = rt_old):
  - 0: {m[7:0], r[23:0]}
  - 1: {m[15:0], r[15:0]}
  - 2: {m[23:0], r[7:0]}
  - 3: m
- LWR (left_or_right=01), by offset 0/1/2/3:
  - 0: m
  - 1: {r[31:24], m[31:8]}
  - 2: {r[31:16], m[31:16]}
  - 3: {r[31:8], m[31:24]}
- Unknown size: store 32'h0.
- Flush, highest priority over a same-cycle request and a same-cycle pop:
  - Next-cycle state: count=0, all pointers equal, out_valid=0.
  - drop_cnt ← drop_cnt + (entries not yet done) − (resp_valid ? 1 : 0).
  - A same-cycle response is itself dropped and sets no resp_err.
- Reset values: all pointers 0, count=0, drop_cnt=0, out_valid=0, out_data=0, resp_err=0, req_ready=0 while rst is high.
- Reset mid-operation drops everything, including in-flight responses. The DCache is reset by the same rst.

Optional Feature:
- Macro: DCACHE_LOAD_UNALIGNED_EN.
- Defined: LWL/LWR merge as above, and rt_old is stored per entry.
- Undefined:
  - left_or_right is ignored and such loads are treated as LW.
  - rt_old storage is not instantiated.
  - req_rt_old stays on the port but is unused.

Decomposition:
- Shared package (CPU_Defines): LoadType struct, plus constants LOADTYPE_LB/LH/LW size encodings and LOADTYPE_LWL/LWR left_or_right encodings, mirroring the StoreType constants.
- Sub-module: load_extract, purely combinational (rdata, offset, loadtype, rt_old → data). It is instantiated once on the response path and unit-tested alone.

Test Plan:
- LB offset 3, rdata 32'h80AA_BBCC, sign=1 → out_data 32'hFFFF_FF80 one cycle after the response; LBU gives 32'h0000_0080.
- LH offset 2, rdata 32'h1234_8001 → 32'h0000_1234. LH offset 0, sign=1 → 32'hFFFF_8001.
- LWL offset 1, rdata 32'hAABB_CCDD, rt_old 32'h1122_3344 → 32'hCCDD_3344. LWR offset 1 → 32'h11AA_BBCC. With the macro undefined, both give 32'hAABB_CCDD.
- DEPTH=2 back-pressure: two requests accepted, out_ready=0, both responses arrive → req_ready=0; the values are preserved in order and drain on out_ready=1.
- Two requests outstanding, flush asserted → out_valid 0. The next two responses are dropped, resp_err stays 0, and a third request's response is delivered correctly.
- resp_valid with nothing outstanding after reset → resp_err pulses once and out_valid stays 0.
